// File: rtl/bcd_7seg_scan_driver.sv
// Three-digit common-anode multiplexed 7-segment driver with per-frame snapshot and saturation blink.
// Optional macro LEADING_ZERO_BLANK_EN blanks leading zero hundreds/tens digits.
module bcd_7seg_scan_driver #(
    parameter int REFRESH_CYCLES = 50000,
    parameter int BLINK_FRAMES   = 16
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [3:0] ones,
    input  logic [3:0] tens,
    input  logic [3:0] hundreds,
    input  logic       saturation,
    output logic [6:0] sseg,
    output logic [2:0] an
);

    localparam int RC_W = $clog2(REFRESH_CYCLES);
    localparam int BC_W = $clog2(BLINK_FRAMES + 1);
    localparam logic [RC_W-1:0] RC_LAST = RC_W'(REFRESH_CYCLES - 1);
    localparam logic [BC_W-1:0] BC_LAST = BC_W'(BLINK_FRAMES);

    function automatic logic [6:0] decode(input logic [3:0] d);
        logic [6:0] seg;
        case (d)
            4'd0:    seg = 7'b1000000;
            4'd1:    seg = 7'b1111001;
            4'd2:    seg = 7'b0100100;
            4'd3:    seg = 7'b0110000;
            4'd4:    seg = 7'b0011001;
            4'd5:    seg = 7'b0010010;
            4'd6:    seg = 7'b0000010;
            4'd7:    seg = 7'b1111000;
            4'd8:    seg = 7'b0000000;
            4'd9:    seg = 7'b0010000;
            default: seg = 7'b0111111;
        endcase
        return seg;
    endfunction

    logic [RC_W-1:0] rc_q, rc_d;
    logic [1:0]      idx_q, idx_d;
    logic [3:0]      ones_q, ones_d, tens_q, tens_d, hund_q, hund_d;
    logic            sat_q, sat_d;
    logic [BC_W-1:0] blink_cnt_q, blink_cnt_d;
    logic            blank_q, blank_d;
    logic            started_q, started_d;
    logic [6:0]      sseg_q, sseg_d;
    logic [2:0]      an_q, an_d;

    logic            wrap_s, frame_start_s, lit_s;
    logic [3:0]      digit_s;
    logic [2:0]      an_sel_s;

    // Scan timing, frame-start snapshot, blink phase and next-state display outputs.
    always_comb begin
        rc_d        = rc_q;
        idx_d       = idx_q;
        ones_d      = ones_q;
        tens_d      = tens_q;
        hund_d      = hund_q;
        sat_d       = sat_q;
        blink_cnt_d = blink_cnt_q;
        blank_d     = blank_q;
        started_d   = 1'b1;
        digit_s     = 4'd0;
        an_sel_s    = 3'b111;
        lit_s       = 1'b0;
        sseg_d      = 7'b1111111;
        an_d        = 3'b111;

        wrap_s = (rc_q == RC_LAST);
        if (wrap_s) begin
            rc_d  = '0;
            idx_d = (idx_q == 2'd2) ? 2'd0 : idx_q + 2'd1;
        end else begin
            rc_d  = rc_q + RC_W'(1);
            idx_d = idx_q;
        end

        // The first edge out of reset counts as a frame start so the display has data at once.
        frame_start_s = !started_q || (wrap_s && (idx_q == 2'd2));

        if (frame_start_s) begin
            ones_d = ones;
            tens_d = tens;
            hund_d = hundreds;
            sat_d  = saturation;
            if (saturation) begin
                if (blink_cnt_q >= BC_LAST) begin
                    blink_cnt_d = BC_W'(1);
                    blank_d     = ~blank_q;
                end else begin
                    blink_cnt_d = blink_cnt_q + BC_W'(1);
                    blank_d     = blank_q;
                end
            end else begin
                blink_cnt_d = '0;
                blank_d     = 1'b0;
            end
        end else begin
            blink_cnt_d = blink_cnt_q;
            blank_d     = blank_q;
        end

        case (idx_d)
            2'd0: begin
                digit_s  = ones_d;
                an_sel_s = 3'b110;
                lit_s    = 1'b1;
            end
            2'd1: begin
                digit_s  = tens_d;
                an_sel_s = 3'b101;
`ifdef LEADING_ZERO_BLANK_EN
                lit_s    = !((hund_d == 4'd0) && (tens_d == 4'd0));
`else
                lit_s    = 1'b1;
`endif
            end
            2'd2: begin
                digit_s  = hund_d;
                an_sel_s = 3'b011;
`ifdef LEADING_ZERO_BLANK_EN
                lit_s    = (hund_d != 4'd0);
`else
                lit_s    = 1'b1;
`endif
            end
            default: begin
                digit_s  = 4'd0;
                an_sel_s = 3'b111;
                lit_s    = 1'b0;
            end
        endcase

        if (blank_d || !lit_s) begin
            sseg_d = 7'b1111111;
            an_d   = 3'b111;
        end else begin
            sseg_d = decode(digit_s);
            an_d   = an_sel_s;
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rc_q        <= '0;
            idx_q       <= 2'd0;
            ones_q      <= 4'd0;
            tens_q      <= 4'd0;
            hund_q      <= 4'd0;
            sat_q       <= 1'b0;
            blink_cnt_q <= '0;
            blank_q     <= 1'b0;
            started_q   <= 1'b0;
            sseg_q      <= 7'b1111111;
            an_q        <= 3'b111;
        end else begin
            rc_q        <= rc_d;
            idx_q       <= idx_d;
            ones_q      <= ones_d;
            tens_q      <= tens_d;
            hund_q      <= hund_d;
            sat_q       <= sat_d;
            blink_cnt_q <= blink_cnt_d;
            blank_q     <= blank_d;
            started_q   <= started_d;
            sseg_q      <= sseg_d;
            an_q        <= an_d;
        end
    end

    assign sseg = sseg_q;
    assign an   = an_q;

endmodule

// File: tb/tb_bcd_7seg_scan_driver.sv
// Table-driven bench for bcd_7seg_scan_driver (REFRESH_CYCLES=4, BLINK_FRAMES=2).
// Expectations for the leading-zero case follow the LEADING_ZERO_BLANK_EN macro.
module tb_bcd_7seg_scan_driver;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [3:0] ones = 4'd0, tens = 4'd0, hundreds = 4'd0;
    logic       saturation = 1'b0;
    logic [6:0] sseg;
    logic [2:0] an;

    int n_checks = 0;
    int n_fail   = 0;

    bcd_7seg_scan_driver #(.REFRESH_CYCLES(4), .BLINK_FRAMES(2)) dut (
        .clk(clk), .reset_n(reset_n), .ones(ones), .tens(tens),
        .hundreds(hundreds), .saturation(saturation), .sseg(sseg), .an(an)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rn;
        logic [3:0] o, t, h;
        logic       s;
        logic [2:0] exp_an;
        logic [6:0] exp_sseg;
    } vec_t;

    vec_t vecs[$];

    localparam logic [6:0] S0 = 7'b1000000, S1 = 7'b1111001, S2 = 7'b0100100,
                           S3 = 7'b0110000, S5 = 7'b0010010, S7 = 7'b1111000,
                           S8 = 7'b0000000, S9 = 7'b0010000, SD = 7'b0111111,
                           SOFF = 7'b1111111;

    task automatic add(input int n, input logic rn, input logic [3:0] o, input logic [3:0] t,
                       input logic [3:0] h, input logic s, input logic [2:0] a, input logic [6:0] g);
        vec_t v;
        v.rn = rn; v.o = o; v.t = t; v.h = h; v.s = s; v.exp_an = a; v.exp_sseg = g;
        for (int i = 0; i < n; i++) vecs.push_back(v);
    endtask

    task automatic check(input string nm, input logic [2:0] ea, input logic [6:0] es);
        n_checks++;
        if (an !== ea) begin
            n_fail++;
            $display("FAIL %s an: got %b expected %b", nm, an, ea);
        end
        n_checks++;
        if (sseg !== es) begin
            n_fail++;
            $display("FAIL %s sseg: got %b expected %b", nm, sseg, es);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    // Three digit slots (ones, tens, hundreds) of a full visible frame.
    task automatic add_frame(input logic [3:0] o, input logic [3:0] t, input logic [3:0] h,
                             input logic s, input logic [6:0] go, input logic [6:0] gt,
                             input logic [6:0] gh);
        add(4, 1'b1, o, t, h, s, 3'b110, go);
        add(4, 1'b1, o, t, h, s, 3'b101, gt);
        add(4, 1'b1, o, t, h, s, 3'b011, gh);
    endtask

    initial begin
        // Reset, then first (short) frame after release and one steady frame of 1-2-3.
        add(3, 1'b0, 4'd3, 4'd2, 4'd1, 1'b0, 3'b111, SOFF);
        add(3, 1'b1, 4'd3, 4'd2, 4'd1, 1'b0, 3'b110, S3);
        add(4, 1'b1, 4'd3, 4'd2, 4'd1, 1'b0, 3'b101, S2);
        add(4, 1'b1, 4'd3, 4'd2, 4'd1, 1'b0, 3'b011, S1);
        add_frame(4'd3, 4'd2, 4'd1, 1'b0, S3, S2, S1);
        // Ones input changes mid-frame; shown only from the next frame start.
        add(4, 1'b1, 4'd3, 4'd2, 4'd1, 1'b0, 3'b110, S3);
        add(4, 1'b1, 4'd7, 4'd2, 4'd1, 1'b0, 3'b101, S2);
        add(4, 1'b1, 4'd7, 4'd2, 4'd1, 1'b0, 3'b011, S1);
        add(4, 1'b1, 4'd7, 4'd2, 4'd1, 1'b0, 3'b110, S7);
        add(4, 1'b1, 4'd7, 4'd2, 4'd1, 1'b0, 3'b101, S2);
        add(1, 1'b1, 4'd7, 4'd2, 4'd1, 1'b0, 3'b011, S1);
        // Reset pulse during the hundreds slot restarts the scan.
        add(1, 1'b0, 4'd7, 4'd2, 4'd1, 1'b0, 3'b111, SOFF);
        add(3, 1'b1, 4'd7, 4'd2, 4'd1, 1'b0, 3'b110, S7);
        add(4, 1'b1, 4'd7, 4'd2, 4'd1, 1'b0, 3'b101, S2);
        add(4, 1'b1, 4'd7, 4'd2, 4'd1, 1'b0, 3'b011, S1);
        // Invalid BCD in hundreds shows a dash.
        add_frame(4'd7, 4'd2, 4'hC, 1'b0, S7, S2, SD);
        // Saturated 999: two frames visible, two blank, visible again.
        add_frame(4'd9, 4'd9, 4'd9, 1'b1, S9, S9, S9);
        add_frame(4'd9, 4'd9, 4'd9, 1'b1, S9, S9, S9);
        add(24, 1'b1, 4'd9, 4'd9, 4'd9, 1'b1, 3'b111, SOFF);
        add_frame(4'd9, 4'd9, 4'd9, 1'b1, S9, S9, S9);
        // Saturation drops: the frame that would have blanked stays visible.
        add_frame(4'd9, 4'd9, 4'd9, 1'b0, S9, S9, S9);
        add_frame(4'd9, 4'd9, 4'd9, 1'b0, S9, S9, S9);
        // Leading zeros: 005.
        add(4, 1'b1, 4'd5, 4'd0, 4'd0, 1'b0, 3'b110, S5);
`ifdef LEADING_ZERO_BLANK_EN
        add(8, 1'b1, 4'd5, 4'd0, 4'd0, 1'b0, 3'b111, SOFF);
`else
        add(4, 1'b1, 4'd5, 4'd0, 4'd0, 1'b0, 3'b101, S0);
        add(4, 1'b1, 4'd5, 4'd0, 4'd0, 1'b0, 3'b011, S0);
`endif

        @(negedge clk);
        for (int i = 0; i < vecs.size(); i++) begin
            reset_n    = vecs[i].rn;
            ones       = vecs[i].o;
            tens       = vecs[i].t;
            hundreds   = vecs[i].h;
            saturation = vecs[i].s;
            tick();
            check($sformatf("vec[%0d]", i), vecs[i].exp_an, vecs[i].exp_sseg);
        end

        // Reset while saturated and blanking is pending: phase returns visible.
        ones = 4'd8; tens = 4'd8; hundreds = 4'd8; saturation = 1'b1;
        reset_n = 1'b0;
        tick();
        check("sat_reset", 3'b111, SOFF);
        reset_n = 1'b1;
        tick();
        check("sat_release", 3'b110, S8);
        // Edges 2..23 are visible with exactly one anode low; edge 24 starts the blank phase.
        for (int e = 2; e <= 23; e++) begin
            tick();
            n_checks++;
            if ($countones(~an) != 1 || sseg !== S8) begin
                n_fail++;
                $display("FAIL onehot edge %0d: got an=%b sseg=%b expected one low anode and %b",
                         e, an, sseg, S8);
            end
        end
        tick();
        check("blank_start", 3'b111, SOFF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/bcd_7seg_scan_driver.md
Name: bcd_7seg_scan_driver

Overview:
Downstream display stage for the multi-decade counter. Takes the three BCD digits (ones/tens/hundreds) and the saturation flag and drives a 3-digit, common-anode, time-multiplexed 7-segment display. Digits are snapshotted once per scan frame so the display never tears, and the display blinks while the counter is saturated.

Parameters:
REFRESH_CYCLES, 50000, clocks each digit stays lit; legal range ≥2. Benches use 4.
BLINK_FRAMES, 16, full scan frames per blink half-period; legal range ≥1. Benches use 2.

Ports:
clk  input  1  system clock; all logic on the rising edge
reset_n  input  1  synchronous, active-low reset
ones  input  4  BCD ones digit from counter
tens  input  4  BCD tens digit from counter
hundreds  input  4  BCD hundreds digit from counter
saturation  input  1  counter saturated flag
sseg  output  7  segments {g,f,e,d,c,b,a}, active-low
an  output  3  digit enables, active-low; an[0]=ones, an[1]=tens, an[2]=hundreds

Behaviour:
- Reset (reset_n low at an edge): sseg=7'b1111111, an=3'b111, refresh counter=0, digit index=0, snapshot=0, blink counter=0, blink phase=visible. Reset dominates everything. Reset mid-scan aborts the frame.
- Refresh counter runs 0..REFRESH_CYCLES-1 and then wraps. On the wrap, the digit index advances 0→1→2→0. Frame length = 3*REFRESH_CYCLES clocks.
- Snapshot registers {ones,tens,hundreds,saturation} load on two edges:
  - the first edge after reset release;
  - every edge where the index wraps 2→0.
  Inputs are ignored at all other times.
- sseg and an are registered and driven from next-state index/snapshot. They change on the same edge as the index, with no extra lag. On the first edge after release: an=3'b110 and ones from that edge's sample are displayed.
- Decode, active-low:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - codes 10–15 display dash 0111111
- Exactly one an bit is low at a time, unless the digit is blanked (then an=3'b111, sseg=7'b1111111).
- Blink:
  - While the snapshot saturation=1, the blink counter counts frame starts.
  - Every BLINK_FRAMES frames the phase toggles visible↔blank.
  - During the blank phase, all digits are blanked.
  - When the snapshot saturation=0, the blink counter clears and the phase is forced visible at that frame start.
  - Saturation rising takes effect only at a frame start.

Optional Feature:
LEADING_ZERO_BLANK_EN:
- Defined: the hundreds digit is blanked when snapshot hundreds==0. The tens digit is blanked when hundreds==0 and tens==0. Ones is never blanked. Blanking applies only to valid zero codes.
- Undefined: all three digits are always shown, e.g. "005".

Test Plan:
1. Reset/startup (REFRESH_CYCLES=4): hold reset_n low for 3 edges with inputs 1,2,3 → an=111, sseg=1111111. First edge after release → an=110, sseg=0110000.
2. Scan (inputs hundreds=1, tens=2, ones=3) → per 12-clock frame: an=110/sseg=0110000 for 4 clocks, then 101/0100100 for 4, then 011/1111001 for 4, repeating.
3. Snapshot: change ones 3→7 while an=101 → the ones slot still shows 0110000 in the current frame, and shows 1111000 from the next frame start. Reset pulse during an=011 → outputs reset next edge, and the scan restarts at an=110.
4. Invalid BCD: hundreds=4'hC → hundreds slot sseg=0111111; other digits unaffected.
5. Blink (BLINK_FRAMES=2): inputs 9,9,9, saturation=1 → 24 clocks visible, 24 clocks an=111/sseg=1111111, repeating. Deassert saturation → normal display from the next frame start.
6. Inputs 0,0,5: with LEADING_ZERO_BLANK_EN → only the ones slot is lit (an=110, sseg=0010010), and an=111 in the tens/hundreds slots. Without the macro → tens/hundreds slots show 1000000.
